// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state type, Booth recode-select type and iteration-count helper
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {ZERO, PM, P2M, NM, N2M} sel_t;
  function automatic int calc_iter(input int n);
    return n / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: combinational radix-4 Booth recode of a 3-bit group into a partial product of the W-bit extended multiplicand
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [2:0]   i_grp,
  input  logic [W-1:0] i_m,
  output logic [W+1:0] o_pp
);
  sel_t         w_sel;
  logic [W+1:0] w_m;
  assign w_m = {{2{i_m[W-1]}}, i_m};
  always_comb begin
    w_sel = (i_grp == 3'b001 || i_grp == 3'b010) ? PM :
            (i_grp == 3'b011)                    ? P2M :
            (i_grp == 3'b100)                    ? N2M :
            (i_grp == 3'b101 || i_grp == 3'b110) ? NM : ZERO;
    o_pp  = (w_sel == PM)  ? w_m :
            (w_sel == P2M) ? (w_m << 1) :
            (w_sel == NM)  ? -w_m :
            (w_sel == N2M) ? -(w_m << 1) : '0;
  end
endmodule

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier: sequential radix-4 Booth multiplier, N/2+1 CALC cycles; BOOTH_SIGNED_MODE_EN adds the signed_mode port (else always signed)
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   data_M,
  input  logic [N-1:0]   data_Q,
`ifdef BOOTH_SIGNED_MODE_EN
  input  logic           signed_mode,
`endif
  output logic [2*N-1:0] data_out,
  output logic           done,
  output logic           busy
);
  localparam int ITER = calc_iter(N);
  localparam int CW = $clog2(ITER + 1);
  state_t       r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N+1:0] r_m, r_q, w_q_nx;
  logic         r_q_m1, w_sgn;
  logic [N+3:0] r_acc, w_pp, w_sum, w_acc_nx;
`ifdef BOOTH_SIGNED_MODE_EN
  assign w_sgn = signed_mode;
`else
  assign w_sgn = 1'b1;
`endif
  booth_r4_encoder #(.W(N + 2)) u_enc (
    .i_grp({r_q[1:0], r_q_m1}),
    .i_m  (r_m),
    .o_pp (w_pp)
  );
  assign w_sum    = r_acc + w_pp;
  assign w_acc_nx = {{2{w_sum[N+3]}}, w_sum[N+3:2]};
  assign w_q_nx   = {w_sum[1:0], r_q[N+1:2]};
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? CALC : IDLE) :
             (r_state == CALC) ? ((r_cnt == CW'(1)) ? DONE : CALC) : IDLE;
    busy   = r_state != IDLE;
    done   = r_state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_q_m1   <= 1'b0;
      data_out <= '0;
    end else if (r_state == IDLE && start) begin
      r_m    <= {{2{w_sgn & data_M[N-1]}}, data_M};
      r_q    <= {{2{w_sgn & data_Q[N-1]}}, data_Q};
      r_q_m1 <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= CW'(ITER);
    end else if (r_state == CALC) begin
      r_acc  <= w_acc_nx;
      r_q    <= w_q_nx;
      r_q_m1 <= r_q[1];
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) data_out <= {w_acc_nx[N-3:0], w_q_nx};
    end
  end
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier: directed self-checking bench for the N=8 Booth multiplier
module tb_booth_radix4_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  data_M = '0;
  logic [7:0]  data_Q = '0;
`ifdef BOOTH_SIGNED_MODE_EN
  logic        sm = 1'b1;
`endif
  logic [15:0] data_out;
  logic        done, busy;
  int          n_chk = 0;
  int          n_fail = 0;
  booth_radix4_multiplier #(.N(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_M(data_M),
    .data_Q(data_Q),
`ifdef BOOTH_SIGNED_MODE_EN
    .signed_mode(sm),
`endif
    .data_out(data_out),
    .done(done),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic mul(input string tag, input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
    int cyc;
    data_M = m;
    data_Q = q;
    start = 1'b1;
    step;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      step;
      cyc++;
    end
    check({tag, "_lat"}, cyc, 5);
    check({tag, "_data"}, data_out, exp);
    step;
    check({tag, "_idle"}, {busy, done}, 0);
    check({tag, "_hold"}, data_out, exp);
  endtask
  initial begin
    int nd, at, at2;
    logic [15:0] d1, d2;
    step;
    step;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_out, 0);
    rst = 1'b0;
    step;
    mul("m3x5", 8'hFD, 8'h05, 16'hFFF1);
    mul("m80x80", 8'h80, 8'h80, 16'h4000);
    mul("m7fx80", 8'h7F, 8'h80, 16'hC080);
`ifdef BOOTH_SIGNED_MODE_EN
    sm = 1'b0;
    mul("uffxff", 8'hFF, 8'hFF, 16'hFE01);
    sm = 1'b1;
`endif
    mul("sffxff", 8'hFF, 8'hFF, 16'h0001);
    data_M = 8'd3;
    data_Q = 8'd4;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    data_M = 8'd7;
    data_Q = 8'd7;
    start = 1'b1;
    step;
    start = 1'b0;
    nd = 0;
    at = 0;
    d1 = '0;
    for (int j = 3; j <= 15; j++) begin
      step;
      if (done) begin
        nd++;
        if (nd == 1) begin
          at = j;
          d1 = data_out;
        end
      end
    end
    check("ign_ndone", nd, 1);
    check("ign_lat", at, 5);
    check("ign_data", d1, 16'h000C);
    data_M = 8'd5;
    data_Q = 8'd6;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_data", data_out, 0);
    nd = 0;
    for (int j = 0; j < 10; j++) begin
      step;
      if (done) nd++;
    end
    check("mrst_ndone", nd, 0);
    check("mrst_idle", busy, 0);
    data_M = 8'd2;
    data_Q = 8'd3;
    start = 1'b1;
    step;
    data_M = 8'hFF;
    data_Q = 8'hFF;
    nd = 0;
    at = 0;
    at2 = 0;
    d1 = '0;
    d2 = '0;
    for (int j = 1; j <= 30 && nd < 2; j++) begin
      step;
      if (done) begin
        nd++;
        if (nd == 1) begin
          at = j;
          d1 = data_out;
        end else begin
          at2 = j;
          d2 = data_out;
        end
      end
    end
    start = 1'b0;
    check("b2b_ndone", nd, 2);
    check("b2b_lat", at, 5);
    check("b2b_gap", at2 - at, 7);
    check("b2b_d1", d1, 16'h0006);
    check("b2b_d2", d2, 16'h0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
